// File: rtl/imem_port_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
package imem_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   err;
  } tag_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_addr_chk.sv
// Byte-address legality check and word-address extraction for one port.
module imem_addr_chk #(
  parameter int IROM_SPACE = 1024,
  parameter int AW         = $clog2(IROM_SPACE)
) (
  input  logic [31:0]   addr,
  output logic          err,
  output logic [AW-1:0] word_addr
);

  // IROM_SPACE is a power of two, so any set bit above the word index is out of range
  assign err       = (addr[1:0] != 2'b00) || (|addr[31:AW+2]);
  assign word_addr = addr[AW+1:2];

endmodule

// File: rtl/imem_port_arb.sv
// Instruction-memory port arbiter between IF fetch and the program loader,
// plus the boot HOLD/RUN/DRAIN sequencer that drives cpu_hold.
//   state | meaning
//   HOLD  | CPU stalled, only the loader is serviced
//   RUN   | fetch and loader arbitrated, loader-priority with starvation cap
//   DRAIN | halt seen; no new fetch grants, back to HOLD next cycle
module imem_port_arb
  import imem_port_arb_pkg::*;
#(
  parameter int IROM_SPACE   = 1024,
  parameter int MAX_LD_BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          boot_done,
  input  logic                          halt_req,
  output logic                          cpu_hold,
  input  logic                          fetch_req,
  input  logic [31:0]                   fetch_addr,
  output logic                          fetch_gnt,
  output logic                          fetch_rvalid,
  output logic [31:0]                   fetch_rdata,
  input  logic                          ld_req,
  input  logic                          ld_we,
  input  logic [31:0]                   ld_addr,
  input  logic [31:0]                   ld_wdata,
  output logic                          ld_gnt,
  output logic                          ld_rvalid,
  output logic [31:0]                   ld_rdata,
  output logic                          ld_err,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [$clog2(IROM_SPACE)-1:0] mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata
);

  localparam int AW = $clog2(IROM_SPACE);
  localparam int SW = $clog2(MAX_LD_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_LD_BURST);

  state_e        state_q, state_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic [SW-1:0] starve_q, starve_d;
  tag_t          tag_q, tag_d;

  logic          f_err, l_err;
  logic [AW-1:0] f_word, l_word;
  logic          fetch_elig;

  imem_addr_chk #(.IROM_SPACE(IROM_SPACE), .AW(AW)) u_chk_fetch (
    .addr      (fetch_addr),
    .err       (f_err),
    .word_addr (f_word)
  );

  imem_addr_chk #(.IROM_SPACE(IROM_SPACE), .AW(AW)) u_chk_ld (
    .addr      (ld_addr),
    .err       (l_err),
    .word_addr (l_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HOLD;
      cpu_hold_q <= 1'b1;
      starve_q   <= '0;
      tag_q      <= '{owner: OWN_NONE, err: 1'b0};
    end else begin
      state_q    <= state_d;
      cpu_hold_q <= cpu_hold_d;
      starve_q   <= starve_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD:  if (boot_done && !halt_req) state_d = ST_RUN;
      ST_RUN:   if (halt_req) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HOLD;
      default:  state_d = ST_HOLD;
    endcase
    cpu_hold_d = (state_d != ST_RUN);
  end

  // Grants are combinational; gating with rst keeps every output low while reset is held
  always_comb begin
    fetch_elig = rst && fetch_req && (state_q == ST_RUN);
    ld_gnt     = rst && ld_req && (!fetch_elig || (starve_q != STARVE_MAX));
    fetch_gnt  = fetch_elig && !ld_gnt;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = '{owner: OWN_NONE, err: 1'b0};

    if (ld_gnt) begin
      if (l_err) begin
        tag_d = '{owner: OWN_LOAD, err: 1'b1};
      end else begin
        mem_en   = 1'b1;
        mem_addr = l_word;
        if (ld_we) begin
          mem_we    = 1'b1;
          mem_wdata = ld_wdata;
        end else begin
          tag_d = '{owner: OWN_LOAD, err: 1'b0};
        end
      end
    end else if (fetch_gnt) begin
      tag_d = '{owner: OWN_FETCH, err: f_err};
      if (!f_err) begin
        mem_en   = 1'b1;
        mem_addr = f_word;
      end
    end

    starve_d = starve_q;
    if (fetch_gnt || !fetch_req) starve_d = '0;
    else if (ld_gnt && fetch_elig && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    cpu_hold     = cpu_hold_q;
    fetch_rvalid = (tag_q.owner == OWN_FETCH);
    ld_rvalid    = (tag_q.owner == OWN_LOAD) && !tag_q.err;
    ld_err       = (tag_q.owner == OWN_LOAD) && tag_q.err;
    fetch_rdata  = '0;
    ld_rdata     = '0;
    if (fetch_rvalid) fetch_rdata = tag_q.err ? RV_NOP : mem_rdata;
    if (ld_rvalid)    ld_rdata    = mem_rdata;
  end

endmodule
